// File: rtl/param_reg_file.sv
// -----------------------------------------------------------------------------
// param_reg_file
//   Parametrised register file with two read ports and one write port for the
//   CPU datapath. A clear sequencer zeroes the array one entry per clock after
//   reset, or when a clear is requested. Because of this the storage itself has
//   no reset. Reads are combinational. An optional write-through bypass and an
//   optional hard-wired zero register are available.
//
// Parameters
//   WIDTH     data width in bits
//   DEPTH     number of entries (>= 2, any value)
//   BYPASS    1: a read of the entry being written returns din_i this cycle
//   ZERO_REG  1: entry 0 reads as 0 and writes to it are discarded
//
// Ports
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset (restarts the clear sweep)
//   din_i      write data
//   adrw_i     write address
//   rf_wr_i    write enable
//   adrx_i     read address, port X
//   adry_i     read address, port Y
//   clr_i      clear-sweep request (level, sampled on clk_i)
//   dx_out_o   read data, port X (combinational, 0 while busy)
//   dy_out_o   read data, port Y (combinational, 0 while busy)
//   busy_o     high while the clear sweep runs
//   wr_drop_o  registered one-cycle pulse: the previous cycle's write was discarded
// -----------------------------------------------------------------------------
module param_reg_file #(
    parameter  int WIDTH    = 8,
    parameter  int DEPTH    = 32,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] din_i,
    input  logic [AW-1:0]    adrw_i,
    input  logic             rf_wr_i,
    input  logic [AW-1:0]    adrx_i,
    input  logic [AW-1:0]    adry_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] dx_out_o,
    output logic [WIDTH-1:0] dy_out_o,
    output logic             busy_o,
    output logic             wr_drop_o
);

    typedef enum logic {
        SWEEP = 1'b0,
        READY = 1'b1
    } state_t;

    // Depth is held one bit wider than an address, so the range check also
    // works when DEPTH is a power of two.
    localparam logic [AW:0]   DEPTH_X  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic             wr_drop_q, wr_drop_d;
    logic             busy_s;
    logic             wr_ok_s;
    logic [WIDTH-1:0] dx_s, dy_s;
    logic [WIDTH-1:0] ram_q [DEPTH];

    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    function automatic logic addr_is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == {AW{1'b0}});
    endfunction

    assign busy_s    = (state_q == SWEEP);
    assign busy_o    = busy_s;
    assign wr_drop_o = wr_drop_q;
    assign dx_out_o  = dx_s;
    assign dy_out_o  = dy_s;

    // Write acceptance: a write is taken only when ready, in range, and not aimed at the zero register.
    always_comb begin
        wr_ok_s   = 1'b0;
        wr_drop_d = 1'b0;
        if (rf_wr_i) begin
            if (!busy_s && addr_in_range(adrw_i) && !addr_is_zero_reg(adrw_i)) begin
                wr_ok_s = 1'b1;
            end else begin
                wr_drop_d = 1'b1;
            end
        end else begin
            wr_ok_s   = 1'b0;
            wr_drop_d = 1'b0;
        end
    end

    // Next-state logic for the clear sequencer.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            SWEEP: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = READY;
                    ptr_d   = {AW{1'b0}};
                end else begin
                    ptr_d   = ptr_q + AW'(1);
                end
            end
            READY: begin
                if (clr_i) begin
                    state_d = SWEEP;
                    ptr_d   = {AW{1'b0}};
                end else begin
                    state_d = READY;
                end
            end
            default: begin
                state_d = SWEEP;
                ptr_d   = {AW{1'b0}};
            end
        endcase
    end

    // Sequencer state, sweep pointer and drop pulse; reset restarts the sweep.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= SWEEP;
            ptr_q     <= {AW{1'b0}};
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Storage array: the sweep writes zeros, otherwise accepted writes land here.
    always_ff @(posedge clk_i) begin
        if (busy_s) begin
            ram_q[ptr_q] <= {WIDTH{1'b0}};
        end else if (wr_ok_s) begin
            ram_q[adrw_i] <= din_i;
        end
    end

    // Read port X: output is forced to 0 while busy, when out of range and for the zero register.
    always_comb begin
        dx_s = {WIDTH{1'b0}};
        if (busy_s || !addr_in_range(adrx_i) || addr_is_zero_reg(adrx_i)) begin
            dx_s = {WIDTH{1'b0}};
        end else if ((BYPASS != 0) && wr_ok_s && (adrx_i == adrw_i)) begin
            dx_s = din_i;
        end else begin
            dx_s = ram_q[adrx_i];
        end
    end

    // Read port Y: same rules as port X.
    always_comb begin
        dy_s = {WIDTH{1'b0}};
        if (busy_s || !addr_in_range(adry_i) || addr_is_zero_reg(adry_i)) begin
            dy_s = {WIDTH{1'b0}};
        end else if ((BYPASS != 0) && wr_ok_s && (adry_i == adrw_i)) begin
            dy_s = din_i;
        end else begin
            dy_s = ram_q[adry_i];
        end
    end

endmodule

// File: tb/tb_param_reg_file.sv
// Bench for param_reg_file. Three instances share one stimulus stream:
//   u0: WIDTH 8,  DEPTH 32, bypass,    no zero register
//   u1: WIDTH 16, DEPTH 24, no bypass, zero register
//   u2: WIDTH 16, DEPTH 5,  bypass,    no zero register (uses the low 3 address bits)
// The driver pushes the expected outputs from a per-instance model into a
// queue. A monitor pops each entry and compares it at the falling edge.
module tb_param_reg_file;

    localparam int DEP  [3] = '{32, 24, 5};
    localparam int MSK  [3] = '{32'hFF, 32'hFFFF, 32'hFFFF};
    localparam int AMSK [3] = '{31, 31, 7};
    localparam int BYP  [3] = '{1, 0, 1};
    localparam int ZRG  [3] = '{0, 1, 0};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rf_wr = 1'b0;
    logic        clr = 1'b0;
    logic [4:0]  adrw = 5'd0, adrx = 5'd0, adry = 5'd0;
    logic [15:0] din = 16'd0;

    logic [7:0]  dx0, dy0;
    logic [15:0] dx1, dy1, dx2, dy2;
    logic        busy0, busy1, busy2, drop0, drop1, drop2;

    always #5 clk = ~clk;

    param_reg_file #(.WIDTH(8), .DEPTH(32), .BYPASS(1), .ZERO_REG(0)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .din_i(din[7:0]), .adrw_i(adrw), .rf_wr_i(rf_wr),
        .adrx_i(adrx), .adry_i(adry), .clr_i(clr), .dx_out_o(dx0), .dy_out_o(dy0),
        .busy_o(busy0), .wr_drop_o(drop0));

    param_reg_file #(.WIDTH(16), .DEPTH(24), .BYPASS(0), .ZERO_REG(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .din_i(din), .adrw_i(adrw), .rf_wr_i(rf_wr),
        .adrx_i(adrx), .adry_i(adry), .clr_i(clr), .dx_out_o(dx1), .dy_out_o(dy1),
        .busy_o(busy1), .wr_drop_o(drop1));

    param_reg_file #(.WIDTH(16), .DEPTH(5), .BYPASS(1), .ZERO_REG(0)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .din_i(din), .adrw_i(adrw[2:0]), .rf_wr_i(rf_wr),
        .adrx_i(adrx[2:0]), .adry_i(adry[2:0]), .clr_i(clr), .dx_out_o(dx2), .dy_out_o(dy2),
        .busy_o(busy2), .wr_drop_o(drop2));

    typedef struct packed {
        logic [2:0][15:0] dx;
        logic [2:0][15:0] dy;
        logic [2:0]       busy;
        logic [2:0]       drop;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: contents, remaining sweep cycles, pending drop pulse.
    int   mem  [3][32];
    int   left [3];
    bit   drp  [3];
    // Inputs applied during the cycle that ends at the next edge.
    bit   p_rst = 1'b0, p_wr = 1'b0, p_clr = 1'b0;
    int   p_adrw = 0, p_din = 0, p_adrx = 0, p_adry = 0;

    function automatic bit accepts(int i, bit r, bit wr, int a);
        return r && wr && (left[i] == 0) && (a < DEP[i]) && !(ZRG[i] != 0 && a == 0);
    endfunction

    function automatic void zero_mem(int i);
        for (int k = 0; k < 32; k++) mem[i][k] = 0;
    endfunction

    function automatic void model_edge(int i);
        int  a;
        bit  acc;
        if (!p_rst) begin
            left[i] = DEP[i];
            drp[i]  = 1'b0;
            zero_mem(i);
        end else begin
            a   = p_adrw & AMSK[i];
            acc = accepts(i, 1'b1, p_wr, a);
            drp[i] = p_wr && !acc;
            if (acc) mem[i][a] = p_din & MSK[i];
            if (left[i] > 0) left[i]--;
            else if (p_clr) begin
                left[i] = DEP[i];
                zero_mem(i);
            end
        end
    endfunction

    function automatic int model_read(int i, int adr);
        int a, aw;
        a  = adr & AMSK[i];
        aw = p_adrw & AMSK[i];
        if (!p_rst || left[i] > 0) return 0;
        if (a >= DEP[i]) return 0;
        if (ZRG[i] != 0 && a == 0) return 0;
        if (BYP[i] != 0 && accepts(i, p_rst, p_wr, aw) && a == aw) return p_din & MSK[i];
        return mem[i][a];
    endfunction

    task automatic cyc(input bit r, input bit wr, input int aw, input int d,
                       input int ax, input int ay, input bit c);
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) model_edge(i);
        rst_n = r; rf_wr = wr; clr = c;
        adrw = 5'(aw); adrx = 5'(ax); adry = 5'(ay); din = 16'(d);
        p_rst = r; p_wr = wr; p_clr = c; p_adrw = aw & 31; p_din = d & 32'hFFFF;
        p_adrx = ax & 31; p_adry = ay & 31;
        for (int i = 0; i < 3; i++) begin
            e.dx[i]   = 16'(model_read(i, p_adrx));
            e.dy[i]   = 16'(model_read(i, p_adry));
            e.busy[i] = !p_rst || left[i] > 0;
            e.drop[i] = p_rst && drp[i];
        end
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 0, 0, $urandom_range(0, 31), $urandom_range(0, 31), 1'b0);
    endtask

    task automatic read_all();
        for (int k = 0; k < 32; k++) cyc(1'b1, 1'b0, 0, 0, k, 31 - k, 1'b0);
    endtask

    task automatic chk(input string nm, input int i, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s u%0d at %0t: got %h expected %h", nm, i, $time, act, exp);
    endtask

    // Monitor: outputs are valid every cycle; compare them to the next queued expectation.
    initial begin
        exp_t e;
        logic [2:0][15:0] ax, ay;
        logic [2:0] ab, ad;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e  = sbq.pop_front();
                ax = {dx2, dx1, {8'h00, dx0}};
                ay = {dy2, dy1, {8'h00, dy0}};
                ab = {busy2, busy1, busy0};
                ad = {drop2, drop1, drop0};
                for (int i = 0; i < 3; i++) begin
                    chk("dx",      i, ax[i], e.dx[i]);
                    chk("dy",      i, ay[i], e.dy[i]);
                    chk("busy",    i, {15'd0, ab[i]}, {15'd0, e.busy[i]});
                    chk("wr_drop", i, {15'd0, ad[i]}, {15'd0, e.drop[i]});
                end
            end
        end
    end

    initial begin
        int a;
        // Reset held with write attempts: no drop pulse may appear during reset.
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, k, 16'h1234, k, k, 1'b0);
        // First sweep: writes during it are dropped.
        for (int k = 0; k < 36; k++) cyc(1'b1, $urandom_range(0, 1) == 1, $urandom_range(0, 31),
                                          $urandom, $urandom_range(0, 31), $urandom_range(0, 31), 1'b0);
        // Fill with junk, pulse reset, and check the full sweep and the zeroed contents.
        for (int k = 0; k < 32; k++) cyc(1'b1, 1'b1, k, $urandom, k, 31 - k, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 3, 4, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 3, 4, 1'b0);
        idle(33);
        read_all();
        // Write 0xA5 to 5 and read it in the write cycle and the next cycle.
        cyc(1'b1, 1'b1, 5, 16'h00A5, 5, 5, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 5, 5, 1'b0);
        // Out-of-range write (27 in the 24-deep file) and zero-register write.
        cyc(1'b1, 1'b1, 27, 16'h0055, 27, 27, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 27, 27, 1'b0);
        cyc(1'b1, 1'b1, 0, 16'h003C, 0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
        // Dual read of the same entry on both ports.
        cyc(1'b1, 1'b1, 31, 16'h007E, 31, 31, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 31, 31, 1'b0);
        cyc(1'b1, 1'b1, 4, 16'h007E, 4, 4, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 4, 4, 1'b0);
        // Clear: fill, request a sweep, request it again mid-sweep, then read back.
        for (int k = 0; k < 32; k++) cyc(1'b1, 1'b1, k, 16'h0010 + k, k, k, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 7, 8, 1'b1);
        idle(10);
        cyc(1'b1, 1'b1, 9, 16'h0099, 9, 9, 1'b1);
        idle(30);
        read_all();
        // Reset at sweep cycle 10, then a full sweep after release.
        for (int k = 0; k < 32; k++) cyc(1'b1, 1'b1, k, 16'h0020 + k, 0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 0, 0, 0, 1'b1);
        idle(10);
        cyc(1'b0, 1'b1, 3, 16'h0011, 3, 3, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 3, 3, 1'b0);
        idle(34);
        read_all();
        // Randomised traffic, biased so that reads often hit the entry being written.
        for (int k = 0; k < 700; k++) begin
            a = $urandom_range(0, 31);
            cyc(1'b1, $urandom_range(0, 2) != 0, a, $urandom,
                ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 31),
                ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 31),
                $urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
